// File: rtl/stream_group_accumulator_pkg.sv
// Shared types and width helpers for the stream group accumulator.
package stream_group_accumulator_pkg;

  // Accumulating elements, or holding a finished total for the downstream.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } sga_state_t;

  // Total width: enough headroom that `group` full-scale elements never wrap.
  function automatic int sga_out_width(input int elem_width, input int group_size);
    return elem_width + $clog2(group_size);
  endfunction

  // Count width: must be able to represent the value `group` itself.
  function automatic int sga_cnt_width(input int group_size);
    return $clog2(group_size + 1);
  endfunction

endpackage : stream_group_accumulator_pkg

// File: rtl/stream_group_accumulator.sv
// Reduces a valid/ready element stream to one widened total per group.
// A group closes after `group` accepted elements, or early on up_last.
// The finished total is held in HOLD, which doubles as the output register,
// so down_valid/down_data/down_count come straight from flops.
module stream_group_accumulator
  import stream_group_accumulator_pkg::*;
#(
  parameter int width     = 8,
  parameter int group     = 4,
  // Derived widths; overriding out_width smaller would allow totals to wrap.
  parameter int out_width = sga_out_width(width, group),
  parameter int cnt_width = sga_cnt_width(group)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [width-1:0]     up_data,
  input  logic                 up_last,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [out_width-1:0] down_data,
  output logic [cnt_width-1:0] down_count
);

  sga_state_t           state_q, state_d;
  logic [out_width-1:0] acc_q, acc_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [out_width-1:0] res_data_q, res_data_d;
  logic [cnt_width-1:0] res_count_q, res_count_d;

  logic                 handshake_s;
  logic                 last_elem_s;
  logic                 close_s;
  logic [out_width-1:0] up_data_ext_s;
  logic [out_width-1:0] acc_sum_s;
  logic [cnt_width-1:0] cnt_inc_s;

  // Ready depends only on state and down_ready, never on up_valid.
  always_comb begin
    up_ready = 1'b1;
    case (state_q)
      ACCUM:   up_ready = 1'b1;
      HOLD:    up_ready = down_ready;
      default: up_ready = 1'b1;
    endcase
  end

  // Handshake qualification and the arithmetic shared by both states.
  always_comb begin
    handshake_s   = up_valid & up_ready;
    last_elem_s   = (cnt_q == cnt_width'(group - 1));
    close_s       = handshake_s & (last_elem_s | up_last);
    up_data_ext_s = out_width'(up_data);
    acc_sum_s     = acc_q + up_data_ext_s;
    cnt_inc_s     = cnt_q + cnt_width'(1);
  end

  // Next-state and register update rules for ACCUM and HOLD.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    case (state_q)
      ACCUM: begin
        if (close_s) begin
          res_data_d  = acc_sum_s;
          res_count_d = cnt_inc_s;
          acc_d       = {out_width{1'b0}};
          cnt_d       = {cnt_width{1'b0}};
          state_d     = HOLD;
        end else if (handshake_s) begin
          acc_d = acc_sum_s;
          cnt_d = cnt_inc_s;
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        // cnt is zero here, so close can only come from up_last.
        if (down_ready) begin
          if (close_s) begin
            res_data_d  = up_data_ext_s;
            res_count_d = cnt_width'(1);
            state_d     = HOLD;
          end else if (handshake_s) begin
            acc_d   = up_data_ext_s;
            cnt_d   = cnt_width'(1);
            state_d = ACCUM;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          // Stalled: everything holds so the presented total stays stable.
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= {out_width{1'b0}};
      cnt_q       <= {cnt_width{1'b0}};
      res_data_q  <= {out_width{1'b0}};
      res_count_q <= {cnt_width{1'b0}};
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
    end
  end

  // Outputs are taken directly from registers.
  always_comb begin
    down_valid = (state_q == HOLD);
    down_data  = res_data_q;
    down_count = res_count_q;
  end

endmodule : stream_group_accumulator

// File: doc/stream_group_accumulator.md
# stream_group_accumulator

Consumes the valid/ready sum stream produced by the FIFO-plus-double-buffer adder and reduces it to one widened total per group of elements. A group closes after `group` accepted elements, or earlier on `up_last`. Each total is presented on a registered valid/ready output together with its element count. Sits directly downstream of the adder's output buffer; `up_*` connects to its `sum_valid`/`sum_ready`/`sum_data`.

## Interface
- `width`, 8, element width of `up_data`
- `group`, 4, elements per full group; legal range ≥ 2
- `out_width`, `width + $clog2(group)`, width of `down_data`; must be derived, never overridden smaller
- `cnt_width`, `$clog2(group + 1)`, width of `down_count`

Ports:
- `clk` input 1 — single clock; all state on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `up_valid` input 1 — upstream element valid
- `up_ready` output 1 — block accepts element this cycle
- `up_data` input `width` — unsigned element
- `up_last` input 1 — qualified by `up_valid`; closes the group on this element
- `down_valid` output 1 — total available
- `down_ready` input 1 — downstream accepts total
- `down_data` output `out_width` — unsigned group total
- `down_count` output `cnt_width` — number of elements in this total, range 1..`group`

## Operation
- Two states, from the shared enum: `ACCUM` and `HOLD`.
- Internal registers: `acc` (`out_width`), `cnt` (`cnt_width`), `res_data`, `res_count`.
- A handshake is `up_valid & up_ready`; `close` = handshake & (`cnt == group-1` | `up_last`).
- `ACCUM`:
  - `up_ready = 1`.
  - Handshake without `close`: `acc <= acc + zext(up_data)`, `cnt <= cnt + 1`.
  - Handshake with `close`: `res_data <= acc + zext(up_data)`, `res_count <= cnt + 1`, `acc <= 0`, `cnt <= 0`, go to `HOLD`.
- `HOLD`:
  - `down_valid = 1`; `down_data = res_data`; `down_count = res_count`.
  - `up_ready = down_ready`. An element is accepted only in the same cycle the total drains.
  - `down_ready` without handshake: go to `ACCUM`.
  - `down_ready` with handshake, not `close`: `acc <= zext(up_data)`, `cnt <= 1`, go to `ACCUM`.
  - `down_ready` with handshake and `up_last` (a 1-element group): load `res_data = zext(up_data)`, `res_count = 1`, stay in `HOLD`.
  - `down_ready = 0`: all registers hold and the output is stable. `down_data`/`down_count` must not change while `down_valid & ~down_ready`.
- Arithmetic: zero-extend `up_data` to `out_width` before adding. With `out_width` derived as above, overflow is impossible.
- `up_last` is ignored when `up_valid = 0`. `up_data`/`up_last` are don't-care when no handshake occurs.

## Timing
- Reset (async assert, any cycle, including mid-group or with `down_valid` high):
  - state `ACCUM`, `acc = 0`, `cnt = 0`, `res_data = 0`, `res_count = 0`.
  - Outputs: `down_valid = 0`, `down_data = 0`, `down_count = 0`, `up_ready = 1`.
  - A partial group in progress is discarded.
- Latency: `down_valid` rises the cycle after the closing handshake.
- Throughput: with `down_ready` held high and `up_valid` continuous, every cycle is accepted with no bubbles. Totals emit every `group` cycles.
- `up_ready` is combinational from state and `down_ready`. There is no combinational path from `up_valid` to `up_ready`, or from `up_valid` to `down_valid`.
- `down_valid`, `down_data`, `down_count` are register outputs only.

## Structure
- Shared package `stream_group_accumulator_pkg` holds:
  - `typedef enum logic {ACCUM, HOLD} sga_state_t`
  - a `function` for `out_width` derivation, reused by the integrating top.
- Single module with no sub-module. Output holding is part of the `HOLD` state, not a separate buffer instance.

## Test plan
- Reset then 4 elements 1, 2, 3, 4, `down_ready = 1`, `group = 4` → one total: `down_data = 10`, `down_count = 4`, `down_valid` one cycle after the 4th handshake.
- Max values, 4 × 255 (`width = 8`) → `down_data = 1020` in 10 bits, no wrap.
- Elements 5, 6 with `up_last` on 6 → `down_data = 11`, `down_count = 2`. The next group starts from zero: 1, 1, 1, 1 → total 4.
- `down_ready = 0` for 5 cycles while `HOLD` with total 10 → `up_ready = 0`, `down_data` stable at 10. When `down_ready` rises with `up_valid` and data 7, the next group contains 7 as its first element.
- Continuous stream 1..8, `down_ready = 1` → totals 10 and 26 on consecutive group boundaries with no `up_ready` deassertion.
- Assert `rst` asynchronously mid-group after 2 elements, and again with `down_valid` high → outputs are 0 immediately, before the next edge. The following 4 elements 2, 2, 2, 2 yield 8.
